// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the register-file write arbiter and its neighbours:
// pipeline writeback, the multi-cycle unit, the hazard unit and the regfile port.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_we;
    logic [4:0]    a_reg;
    logic [31:0]   a_data;
    logic          b_valid;
    logic [4:0]    b_reg;
    logic [31:0]   b_data;
    logic          b_ready;
    logic          sb_set;
    logic [4:0]    sb_reg;
    logic [4:0]    rs_addr;
    logic [4:0]    rt_addr;
    logic          rs_busy;
    logic          rt_busy;
    logic          RegWrite;
    logic [4:0]    W_reg;
    logic [31:0]   W_data;
    logic          pipe_stall;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  a_we, a_reg, a_data, b_valid, b_reg, b_data,
               sb_set, sb_reg, rs_addr, rt_addr,
        output b_ready, rs_busy, rt_busy, RegWrite, W_reg, W_data,
               pipe_stall, fifo_count
    );

    modport master (
        output a_we, a_reg, a_data, b_valid, b_reg, b_data,
               sb_set, sb_reg, rs_addr, rt_addr,
        input  b_ready, rs_busy, rt_busy, RegWrite, W_reg, W_data,
               pipe_stall, fifo_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, multi-cycle results queue and drain
// on idle cycles, with a busy scoreboard. Define RF_ARB_BYPASS_EN to let B write an idle port directly.
module rf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic            clk,
    input logic            rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    logic [4:0]    q_reg  [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nx;
    logic [31:0]   busy, busy_nx, set_mask, clr_mask;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic          stall, stall_nx;
    logic          empty, full, b_fire, push, pop, byp, b_commit;
    logic          sel_vld;
    logic [4:0]    sel_reg;
    logic [31:0]   sel_data;

    always_comb begin
        empty  = (count == '0);
        full   = (count == FULL_CNT);
        b_fire = bus.b_valid && rst_n && !full;
`ifdef RF_ARB_BYPASS_EN
        byp = rst_n && empty && !bus.a_we && bus.b_valid;
`else
        byp = 1'b0;
`endif
        pop  = rst_n && !bus.a_we && !empty;
        // Register-0 results complete the handshake but never occupy a slot.
        push = b_fire && (bus.b_reg != 5'd0) && !byp;

        sel_vld  = 1'b0;
        sel_reg  = 5'd0;
        sel_data = 32'd0;
        if (bus.a_we) begin
            sel_vld  = 1'b1;
            sel_reg  = bus.a_reg;
            sel_data = bus.a_data;
        end else if (!empty) begin
            sel_vld  = 1'b1;
            sel_reg  = q_reg[rd_ptr];
            sel_data = q_data[rd_ptr];
        end else if (byp) begin
            sel_vld  = 1'b1;
            sel_reg  = bus.b_reg;
            sel_data = bus.b_data;
        end

        // Only port-B commits retire scoreboard entries; a same-cycle set overrides the clear.
        b_commit = pop || byp;
        clr_mask = b_commit ? (32'd1 << sel_reg) : 32'd0;
        set_mask = (bus.sb_set && bus.sb_reg != 5'd0) ? (32'd1 << bus.sb_reg) : 32'd0;
        busy_nx  = (busy & ~clr_mask) | set_mask;

        count_nx = count + CW'(push) - CW'(pop);

        wait_nx = '0;
        if (!empty && bus.a_we)
            wait_nx = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + WW'(1);

        stall_nx = (count_nx == FULL_CNT) || (wait_nx == WAIT_LIM);
    end

    assign bus.b_ready    = rst_n && !full;
    assign bus.RegWrite   = rst_n && sel_vld && (sel_reg != 5'd0);
    assign bus.W_reg      = rst_n ? sel_reg : 5'd0;
    assign bus.W_data     = rst_n ? sel_data : 32'd0;
    assign bus.rs_busy    = busy[bus.rs_addr];
    assign bus.rt_busy    = busy[bus.rt_addr];
    assign bus.fifo_count = count;
    assign bus.pipe_stall = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            busy     <= '0;
            wait_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count    <= count_nx;
            busy     <= busy_nx;
            wait_cnt <= wait_nx;
            stall    <= stall_nx;
        end
    end

    // Payload storage carries no reset; the cleared pointers make stale slots unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= bus.b_reg;
            q_data[wr_ptr] <= bus.b_data;
        end
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers: the in-order pipeline writeback (port A) and a multi-cycle unit such as mul/div or a late load (port B).
- Port A always wins and is never back-pressured.
- Port B writes queue in a small FIFO and drain on idle write-port cycles.
- A 32-entry scoreboard tracks destinations of outstanding port-B operations so the hazard unit can stall dependent reads.
- A wait counter forces pipeline bubbles so port B cannot starve.

Parameters:
DEPTH, 2, port-B FIFO entries (power of 2, >=2)
MAX_WAIT, 4, cycles a non-empty FIFO head may be blocked before a bubble is requested (>=1)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
a_we  input  1  pipeline writeback valid this cycle
a_reg  input  5  pipeline destination register
a_data  input  32  pipeline write data
b_valid  input  1  multi-cycle unit result valid
b_reg  input  5  multi-cycle destination register
b_data  input  32  multi-cycle result data
b_ready  output  1  FIFO can accept a port-B result
sb_set  input  1  multi-cycle op issued; mark sb_reg busy
sb_reg  input  5  destination of the issued op
rs_addr  input  5  decode-stage source 1
rt_addr  input  5  decode-stage source 2
rs_busy  output  1  rs_addr has an outstanding port-B write
rt_busy  output  1  rt_addr has an outstanding port-B write
RegWrite  output  1  register file write enable
W_reg  output  5  register file write address
W_data  output  32  register file write data
pipe_stall  output  1  registered request for a writeback bubble next cycle
fifo_count  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count cleared; busy[31:0] cleared; wait counter cleared; pipe_stall=0.
  - RegWrite, W_reg and W_data are forced to 0 while rst_n is low.
  - b_ready=0 while rst_n is low.
  - A reset mid-operation discards all queued B results and all busy bits.
- Write-port mux (combinational, same cycle):
  - If a_we=1, drive {1, a_reg, a_data}.
  - Else if the FIFO is non-empty, drive the FIFO head and pop it at posedge.
  - Else RegWrite=0.
  - The register file samples on negedge, so data is written in the same cycle.
- Register 0: any commit with W_reg=0 has RegWrite forced to 0. A port-B result with b_reg=0 is accepted (handshake completes) but not enqueued.
- Port-B handshake:
  - b_ready = (fifo_count<DEPTH).
  - Transfer occurs when b_valid&&b_ready at posedge; data enqueues at the tail.
  - A write and a pop in the same cycle when the FIFO is full are not allowed (b_ready=0 when full). Push and pop in the same cycle with count<DEPTH leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - sb_set sets busy[sb_reg]; register 0 is never set.
  - A port-B commit from the FIFO clears busy[W_reg].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - Port-A commits never touch busy.
  - rs_busy = busy[rs_addr] and rt_busy = busy[rt_addr], combinational from the registered bits.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and a_we=1, saturating at MAX_WAIT.
  - Clears on any FIFO pop or when the FIFO is empty.
- pipe_stall (registered): next value = (next count==DEPTH) || (next wait==MAX_WAIT).
  - The pipeline guarantees a_we=0 in any cycle where pipe_stall=1, so the head drains in that cycle.
  - If a_we=1 anyway, port A still wins; no write is ever dropped.
- Ordering: port-B results commit in acceptance order. Port A and port B never write in the same cycle.

Optional Feature:
RF_ARB_BYPASS_EN
- Defined: when fifo_count==0, a_we=0 and b_valid=1, the B result drives the write port directly in that cycle.
  - It is not enqueued; busy is cleared at posedge; b_ready stays 1.
  - This gives zero-cycle latency on an idle port.
- Undefined: every B result enqueues first, so the minimum accept-to-write latency is 1 cycle.

Test Plan:
- Reset, then b_valid with b_reg=5, b_data=0x1234, a_we=0 -> next cycle RegWrite=1, W_reg=5, W_data=0x1234 (same cycle if RF_ARB_BYPASS_EN); fifo_count returns to 0.
- a_we=1 continuously (a_reg=3) while B pushes regs 7 and 8 (DEPTH=2) -> b_ready falls when fifo_count=2 and pipe_stall=1 next cycle; with a_we=0 then, reg 7 commits, then reg 8, in order.
- B holds one entry with a_we=1 for 4 cycles (MAX_WAIT=4) -> pipe_stall=1 in cycle 5; the head commits when a_we=0; the wait counter clears.
- sb_set reg 9 -> rs_busy=1 for rs_addr=9; B commit to 9 -> rs_busy=0 the following cycle. sb_set 9 in the same cycle as the commit -> busy stays 1.
- b_reg=0 with data 0xFFFF -> handshake completes, fifo_count unchanged, RegWrite never asserted; a_we with a_reg=0 -> RegWrite=0.
- Assert rst_n=0 asynchronously with the FIFO full and busy bits set -> immediately RegWrite=0, b_ready=0; after release, fifo_count=0, all busy=0, pipe_stall=0.
